// File: rtl/main_mem_lat_pkg.sv
// rtl/main_mem_lat_pkg.sv - shared types and lane-mask helpers for main_mem_lat
package main_mem_lat_pkg;

  typedef enum logic [1:0] {
    ACC_SZ_8  = 2'd0,
    ACC_SZ_16 = 2'd1,
    ACC_SZ_32 = 2'd2,
    ACC_SZ_64 = 2'd3
  } acc_sz_e;

  typedef enum logic {
    ACC_READ  = 1'b0,
    ACC_WRITE = 1'b1
  } acc_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int PORT_DATA_WIDTH = 64;
  localparam int PORT_ADDR_WIDTH = 32;

  typedef struct packed {
    logic                       req;
    acc_type_e                  acc_type;
    acc_sz_e                    acc_sz;
    logic [PORT_ADDR_WIDTH-1:0] addr;
    logic [PORT_DATA_WIDTH-1:0] data;
  } port_in_t;

  typedef struct packed {
    logic                       busy;
    logic                       valid;
    logic [PORT_DATA_WIDTH-1:0] data;
    logic                       err;
  } port_out_t;

  // One bit per byte lane covered by an access of this size at offset 0.
  function automatic logic [7:0] size_mask(acc_sz_e sz);
    case (sz)
      ACC_SZ_8:  return 8'h01;
      ACC_SZ_16: return 8'h03;
      ACC_SZ_32: return 8'h0f;
      default:   return 8'hff;
    endcase
  endfunction

  function automatic logic [7:0] lane_mask(acc_sz_e sz, logic [2:0] off);
    return size_mask(sz) << off;
  endfunction

endpackage

// File: rtl/main_mem_lat_lanes.sv
// rtl/main_mem_lat_lanes.sv - byte-lane write merge and read extract/zero-extend
module main_mem_lat_lanes
  import main_mem_lat_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OFF_W      = 2
) (
  input  logic [DATA_WIDTH-1:0] old_word,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  acc_sz_e               acc_sz,
  input  logic [OFF_W-1:0]      offset,
  output logic [DATA_WIDTH-1:0] merged_word,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int NB = DATA_WIDTH / 8;

  logic [NB-1:0]         wr_lanes;
  logic [NB-1:0]         keep_lanes;
  logic [DATA_WIDTH-1:0] wr_bits;
  logic [DATA_WIDTH-1:0] keep_bits;
  logic [OFF_W+2:0]      shamt;

  always_comb begin
    wr_lanes   = NB'(lane_mask(acc_sz, 3'(offset)));
    keep_lanes = NB'(size_mask(acc_sz));
    shamt      = {offset, 3'b000};
    wr_bits    = '0;
    keep_bits  = '0;
    for (int k = 0; k < NB; k++) begin
      wr_bits[8*k +: 8]   = {8{wr_lanes[k]}};
      keep_bits[8*k +: 8] = {8{keep_lanes[k]}};
    end
    merged_word = ((wr_data << shamt) & wr_bits) | (old_word & ~wr_bits);
    rd_data     = (old_word >> shamt) & keep_bits;
  end

endmodule

// File: rtl/main_mem_lat.sv
// rtl/main_mem_lat.sv - latency-configurable main memory; MAIN_MEM_LAT_MISALIGN_TRAP_EN adds out_err trapping
module main_mem_lat
  import main_mem_lat_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_WORDS_LOG2 = 14,
  parameter int LATENCY        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_req,
  input  logic                  in_acc_type,
  input  logic [1:0]            in_acc_sz,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_busy,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef MAIN_MEM_LAT_MISALIGN_TRAP_EN
  ,
  output logic                  out_err
`endif
);

  localparam int NB      = DATA_WIDTH / 8;
  localparam int OFF     = $clog2(NB);
  localparam int AW_USED = OFF + MEM_WORDS_LOG2;
  localparam int DEPTH   = 1 << MEM_WORDS_LOG2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  type_q, type_d;
  acc_sz_e               sz_q, sz_d;
  logic [AW_USED-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mem_we;

  acc_sz_e               sz_eff;
  logic [OFF-1:0]        off_raw, off_eff, off_low;
  logic                  bad_acc;
  logic [DATA_WIDTH-1:0] merged_word, rd_word;
  logic [MEM_WORDS_LOG2-1:0] word_idx;

  generate
    if (ADDR_WIDTH > AW_USED) begin : g_addr_wrap
      logic unused_addr_hi;
      assign unused_addr_hi = ^in_addr[ADDR_WIDTH-1:AW_USED];
    end
  endgenerate

  // Size 3 on a 32-bit bus degrades to a word access; bad_acc only matters when trapping.
  always_comb begin
    sz_eff   = (DATA_WIDTH == 32 && sz_q == ACC_SZ_64) ? ACC_SZ_32 : sz_q;
    off_raw  = addr_q[OFF-1:0];
    off_low  = OFF'(size_mask(sz_eff) >> 1);
    word_idx = addr_q[AW_USED-1:OFF];
`ifdef MAIN_MEM_LAT_MISALIGN_TRAP_EN
    bad_acc  = ((off_raw & off_low) != '0) || (DATA_WIDTH == 32 && sz_q == ACC_SZ_64);
    off_eff  = off_raw;
`else
    bad_acc  = 1'b0;
    off_eff  = off_raw & ~off_low;
`endif
  end

  main_mem_lat_lanes #(
    .DATA_WIDTH (DATA_WIDTH),
    .OFF_W      (OFF)
  ) u_lanes (
    .old_word    (mem[word_idx]),
    .wr_data     (wdata_q),
    .acc_sz      (sz_eff),
    .offset      (off_eff),
    .merged_word (merged_word),
    .rd_data     (rd_word)
  );

`ifdef MAIN_MEM_LAT_MISALIGN_TRAP_EN
  logic err_q, err_d;
  assign out_err = err_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    sz_d    = sz_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valid_d = 1'b0;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
`ifdef MAIN_MEM_LAT_MISALIGN_TRAP_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_req) begin
          type_d  = in_acc_type;
          sz_d    = acc_sz_e'(in_acc_sz);
          addr_d  = in_addr[AW_USED-1:0];
          wdata_d = in_data;
          cnt_d   = 4'(LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_RESP;
          valid_d = 1'b1;
          if (bad_acc) begin
            rdata_d = '0;
`ifdef MAIN_MEM_LAT_MISALIGN_TRAP_EN
            err_d   = 1'b1;
`endif
          end else if (type_q == ACC_WRITE) begin
            rdata_d = '0;
            mem_we  = 1'b1;
          end else begin
            rdata_d = rd_word;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      type_q  <= 1'b0;
      sz_q    <= ACC_SZ_8;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
`ifdef MAIN_MEM_LAT_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      sz_q    <= sz_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
`ifdef MAIN_MEM_LAT_MISALIGN_TRAP_EN
      err_q   <= err_d;
`endif
    end
  end

  // Storage is never reset; a reset in WAIT suppresses the pending write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[word_idx] <= merged_word;
    end
  end

  assign out_busy  = (state_q != ST_IDLE);
  assign out_valid = valid_q;
  assign out_data  = rdata_q;

endmodule
